// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: stall/flush control plus optional
// EX/MEM and MEM/WB operand forwarding, enabled by defining ID_EX_FORWARD_EN.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [RA_W-1:0]  rs_addr,
    input  logic [RA_W-1:0]  rt_addr,
    input  logic [RA_W-1:0]  rd_addr,
    input  logic             alu_src,
    input  logic [3:0]       ALUctrl_in,
    input  logic [4:0]       shiftAmount_in,
    input  logic             reg_write_in,
    input  logic             exmem_reg_write,
    input  logic             memwb_reg_write,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             out_valid,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    output logic [3:0]       ALUctrl,
    output logic [4:0]       shiftAmount,
    output logic [WIDTH-1:0] store_data,
    output logic [RA_W-1:0]  rd_addr_out,
    output logic             reg_write_out
);

    logic             r_valid;
    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic [WIDTH-1:0] r_imm;
    logic [RA_W-1:0]  r_rs_addr;
    logic [RA_W-1:0]  r_rt_addr;
    logic [RA_W-1:0]  r_rd_addr;
    logic             r_alu_src;
    logic [3:0]       r_aluctrl;
    logic [4:0]       r_shamt;
    logic             r_reg_write;

    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;

    // A flush outranks stall so a squashed instruction never lingers in EX.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid     <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd_addr   <= '0;
            r_alu_src   <= 1'b0;
            r_aluctrl   <= 4'b0000;
            r_shamt     <= '0;
            r_reg_write <= 1'b0;
        end else if (!stall) begin
            r_valid     <= in_valid;
            r_rs_data   <= rs_data;
            r_rt_data   <= rt_data;
            r_imm       <= imm;
            r_rs_addr   <= rs_addr;
            r_rt_addr   <= rt_addr;
            r_rd_addr   <= rd_addr;
            r_alu_src   <= alu_src;
            r_aluctrl   <= ALUctrl_in;
            r_shamt     <= shiftAmount_in;
            r_reg_write <= reg_write_in & in_valid;
        end
    end

`ifdef ID_EX_FORWARD_EN
    logic w_rs_exmem, w_rs_memwb, w_rt_exmem, w_rt_memwb;

    // Register $0 is hardwired to zero and must never pick up a forwarded value.
    assign w_rs_exmem = exmem_reg_write && (exmem_rd == r_rs_addr) && (r_rs_addr != '0);
    assign w_rs_memwb = memwb_reg_write && (memwb_rd == r_rs_addr) && (r_rs_addr != '0);
    assign w_rt_exmem = exmem_reg_write && (exmem_rd == r_rt_addr) && (r_rt_addr != '0);
    assign w_rt_memwb = memwb_reg_write && (memwb_rd == r_rt_addr) && (r_rt_addr != '0);

    always_comb begin
        w_fwd_rs = r_rs_data;
        if (w_rs_exmem)      w_fwd_rs = exmem_result;
        else if (w_rs_memwb) w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (w_rt_exmem)      w_fwd_rt = exmem_result;
        else if (w_rt_memwb) w_fwd_rt = memwb_result;
    end
`else
    logic w_unused_fwd;

    assign w_fwd_rs     = r_rs_data;
    assign w_fwd_rt     = r_rt_data;
    assign w_unused_fwd = ^{exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
                            exmem_result, memwb_result, r_rs_addr, r_rt_addr};
`endif

    assign input1        = w_fwd_rs;
    assign input2        = r_alu_src ? r_imm : w_fwd_rt;
    assign store_data    = w_fwd_rt;
    assign out_valid     = r_valid;
    assign ALUctrl       = r_aluctrl;
    assign shiftAmount   = r_shamt;
    assign rd_addr_out   = r_rd_addr;
    assign reg_write_out = r_reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan steps followed by random traffic
// checked against a transaction-level model of the stage and forwarding rules.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, alu_src, reg_write_in;
    logic [31:0] rs_data, rt_data, imm, exmem_result, memwb_result;
    logic [4:0]  rs_addr, rt_addr, rd_addr, exmem_rd, memwb_rd, shiftAmount_in;
    logic [3:0]  ALUctrl_in;
    logic        exmem_reg_write, memwb_reg_write;
    logic        out_valid, reg_write_out;
    logic [31:0] input1, input2, store_data;
    logic [3:0]  ALUctrl;
    logic [4:0]  shiftAmount, rd_addr_out;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Instruction currently held in EX, as seen by the reference model.
    typedef struct {
        logic        v, src, rw;
        logic [31:0] rs, rt, imm;
        logic [4:0]  rsa, rta, rda, sh;
        logic [3:0]  op;
    } instr_t;
    instr_t m;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .ALUctrl_in(ALUctrl_in), .shiftAmount_in(shiftAmount_in),
        .reg_write_in(reg_write_in),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .out_valid(out_valid), .input1(input1), .input2(input2), .ALUctrl(ALUctrl),
        .shiftAmount(shiftAmount), .store_data(store_data),
        .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] raw);
        if (!FWD || a == 5'd0) return raw;
        if (exmem_reg_write && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd == a) return memwb_result;
        return raw;
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] e_rt;
        e_rt = fwd(m.rta, m.rt);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m.v});
        chk({tag, ".in1"}, input1, fwd(m.rsa, m.rs));
        chk({tag, ".in2"}, input2, m.src ? m.imm : e_rt);
        chk({tag, ".store"}, store_data, e_rt);
        chk({tag, ".op"}, {28'd0, ALUctrl}, {28'd0, m.op});
        chk({tag, ".sh"}, {27'd0, shiftAmount}, {27'd0, m.sh});
        chk({tag, ".rd"}, {27'd0, rd_addr_out}, {27'd0, m.rda});
        chk({tag, ".rw"}, {31'd0, reg_write_out}, {31'd0, m.rw});
    endtask

    // One clock edge: the model applies rst > flush > stall > load to the same inputs.
    task automatic tick();
        @(posedge clk);
        if (rst || flush) m = '{default: '0};
        else if (!stall) begin
            m.v = in_valid;  m.rs = rs_data;  m.rt = rt_data;  m.imm = imm;
            m.rsa = rs_addr; m.rta = rt_addr; m.rda = rd_addr; m.src = alu_src;
            m.op = ALUctrl_in; m.sh = shiftAmount_in; m.rw = reg_write_in && in_valid;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; stall = 0; flush = 0; alu_src = 0; reg_write_in = 0;
        rs_data = 0; rt_data = 0; imm = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0;
        ALUctrl_in = 0; shiftAmount_in = 0;
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_result = 0;
    endtask

    initial begin
        m = '{default: '0};
        idle_inputs();

        // Reset with every input nonzero
        rst = 1; in_valid = 1; stall = 1; flush = 1; alu_src = 1; reg_write_in = 1;
        rs_data = 32'hAAAA_0001; rt_data = 32'h5555_0002; imm = 32'h1234_5678;
        rs_addr = 5'd7; rt_addr = 5'd9; rd_addr = 5'd11; ALUctrl_in = 4'hF; shiftAmount_in = 5'd31;
        exmem_reg_write = 1; memwb_reg_write = 1; exmem_rd = 5'd7; memwb_rd = 5'd9;
        exmem_result = 32'hDEAD_BEEF; memwb_result = 32'hCAFE_F00D;
        tick(); tick();
        chk("reset.in1", input1, 32'd0);
        chk("reset.in2", input2, 32'd0);
        chk("reset.store", store_data, 32'd0);
        check_model("reset");

        // Plain load
        idle_inputs();
        rs_data = 4; rt_data = 8; shiftAmount_in = 6; in_valid = 1; rs_addr = 5'd3;
        tick();
        chk("load.in1", input1, 32'd4);
        chk("load.in2", input2, 32'd8);
        chk("load.sh", {27'd0, shiftAmount}, 32'd6);
        chk("load.valid", {31'd0, out_valid}, 32'd1);
        check_model("load");

        // Forwarding priority on registered rs_addr=3 (combinational, no edge)
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 10;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 12;
        #1 chk("fwd.exmem", input1, FWD ? 32'd10 : 32'd4);
        exmem_reg_write = 0;
        #1 chk("fwd.memwb", input1, FWD ? 32'd12 : 32'd4);
        check_model("fwd");
        exmem_reg_write = 1; rs_addr = 0; rs_data = 32'd77;
        tick();
        chk("fwd.r0", input1, 32'd77);

        // Stall holds 4/8/0000 while new data waits
        rs_data = 4; rt_data = 8; rs_addr = 0; ALUctrl_in = 0;
        exmem_reg_write = 0; memwb_reg_write = 0;
        tick();
        stall = 1; rs_data = 3; rt_data = 9; ALUctrl_in = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.in1", input1, 32'd4);
            chk("stall.in2", input2, 32'd8);
            chk("stall.op", {28'd0, ALUctrl}, 32'd0);
        end
        stall = 0;
        tick();
        chk("unstall.in1", input1, 32'd3);
        chk("unstall.in2", input2, 32'd9);
        chk("unstall.op", {28'd0, ALUctrl}, 32'd2);

        // Flush beats stall
        reg_write_in = 1; ALUctrl_in = 4'b0111; in_valid = 1;
        tick();
        flush = 1; stall = 1;
        tick();
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        chk("flush.rw", {31'd0, reg_write_out}, 32'd0);
        chk("flush.op", {28'd0, ALUctrl}, 32'd0);
        check_model("flush");
        flush = 0; stall = 0;

        // Immediate operand
        rt_data = 2; imm = 17; alu_src = 1; ALUctrl_in = 4'b0111; rt_addr = 0;
        tick();
        chk("imm.in2", input2, 32'd17);
        chk("imm.store", store_data, 32'd2);
        chk("imm.op", {28'd0, ALUctrl}, 32'd7);

        // Random traffic with small register numbers so forwarding hits often
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            in_valid = $urandom_range(0, 1); reg_write_in = $urandom_range(0, 1);
            alu_src = $urandom_range(0, 1);
            rs_data = $urandom; rt_data = $urandom; imm = $urandom;
            rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
            rd_addr = 5'($urandom); ALUctrl_in = 4'($urandom); shiftAmount_in = 5'($urandom);
            exmem_reg_write = $urandom_range(0, 1); memwb_reg_write = $urandom_range(0, 1);
            exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom; memwb_result = $urandom;
            tick();
            check_model("rand");
            // Forwarding inputs change mid-cycle; operands must follow at once
            exmem_reg_write = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            #1 check_model("rand_fwd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
